// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default hang threshold for the pipeline controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2,
        HANG     = 2'd3
    } state_e;

    localparam int WAIT_MAX_DEF = 255;

endpackage

// File: rtl/pipe_ctrl_wait_timer.sv
// wait_timer: saturating wait-cycle counter; expired flags the cycle the count reaches MAX.
module wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX = WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // expired looks at the next count so the hang is taken on the edge that reaches MAX
    always_comb begin
        cnt_d   = clr ? '0 : (en && cnt_q != W'(MAX)) ? cnt_q + W'(1) : cnt_q;
        expired = !clr && cnt_d == W'(MAX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline hazard controller producing stall/flush controls,
// multi-cycle unit start pulses and a sticky hang flag for runaway wait states.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_br_taken,
    input  logic       ex_mdu,
    input  logic       mdu_done,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       fstall,
    output logic       dstall,
    output logic       estall,
    output logic       mstall,
    output logic       dflush,
    output logic       eflush,
    output logic       mflush,
    output logic       wflush,
    output logic       mdu_go,
    output logic [1:0] state,
    output logic       err
);

    state_e state_q, state_d;
    logic   err_q, err_d;
    logic   load_use, tmr_en, tmr_clr, expired;

    assign load_use = ex_memread && ex_rd != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign tmr_clr  = state_q == RUN;
    assign tmr_en   = (state_q == MDU_WAIT && !mdu_done) || (state_q == MEM_WAIT && !mem_ready);

    wait_timer #(.MAX(WAIT_MAX)) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        {fstall, dstall, estall, mstall} = 4'b0000;
        {dflush, eflush, mflush, wflush} = 4'b0000;
        mdu_go  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    {fstall, dstall, estall, mstall, wflush} = 5'b11111;
                    state_d = MEM_WAIT;
                end else if (ex_mdu) begin
                    {fstall, dstall, estall, mflush, mdu_go} = 5'b11111;
                    state_d = MDU_WAIT;
                end else if (ex_br_taken) begin
                    {dflush, eflush} = 2'b11;
                end else if (load_use) begin
                    {fstall, dstall, eflush} = 3'b111;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_d = RUN;
                end else begin
                    {fstall, dstall, estall, mflush} = 4'b1111;
                    if (expired) begin
                        state_d = HANG;
                        err_d   = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    {fstall, dstall, estall, mstall, wflush} = 5'b11111;
                    if (expired) begin
                        state_d = HANG;
                        err_d   = 1'b1;
                    end
                end
            end
            HANG: begin
                {fstall, dstall, estall, mstall} = 4'b1111;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign state = state_q;
    assign err   = err_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 255, maximum consecutive wait-state cycles before the block declares a hang.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports id_rs1, id_rs2  in  5 each  ID-stage source register indices.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 SHALL have ports ex_rd  in  5 (EX destination index) and ex_memread  in  1 (EX holds a load).
REQ-007 SHALL have ports ex_br_taken  in  1  (EX resolved a redirect) and ex_mdu  in  1  (EX holds a multi-cycle MUL/DIV).
REQ-008 SHALL have port mdu_done  in  1  multi-cycle unit result valid, one-cycle pulse.
REQ-009 SHALL have ports mem_req  in  1 and mem_ready  in  1  MEM-stage data access handshake.
REQ-010 SHALL have outputs fstall, dstall, estall, mstall  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM registers.
REQ-011 SHALL have outputs dflush, eflush, mflush, wflush  out  1 each  bubble into IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-012 SHALL have outputs mdu_go  out  1 (start pulse to the multi-cycle unit), state  out  2, err  out  1 (sticky hang flag).

Function
REQ-013 SHALL implement FSM states RUN=0, MDU_WAIT=1, MEM_WAIT=2, HANG=3, exposed on state.
REQ-014 Stall/flush outputs and mdu_go SHALL be combinational from state and current inputs; state, wait counter and err SHALL be registered.
REQ-015 RUN, priority 1: mem_req && !mem_ready -> all four stalls and wflush asserted, next state MEM_WAIT; all other requests ignored that cycle.
REQ-016 RUN, priority 2: ex_mdu -> mdu_go=1 for exactly that cycle, fstall=dstall=estall=1, mflush=1, next state MDU_WAIT.
REQ-017 RUN, priority 3: ex_br_taken -> dflush=eflush=1, no stalls.
REQ-018 RUN, priority 4: load-use when ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)) -> fstall=dstall=eflush=1.
REQ-019 Register index 0 SHALL never trigger load-use.
REQ-020 MDU_WAIT: fstall=dstall=estall=mflush=1 until mdu_done; on the mdu_done cycle all outputs 0 and next state RUN; mdu_go SHALL NOT reassert in MDU_WAIT.
REQ-021 MEM_WAIT: all four stalls and wflush=1 while !mem_ready; on the mem_ready cycle all outputs 0 and next state RUN.
REQ-022 An ex_mdu pending behind a memory wait SHALL issue mdu_go on the first RUN cycle after MEM_WAIT exits (EX held, request persists).
REQ-023 Wait counter SHALL clear on entry to any wait state, increment each wait cycle, saturate at WAIT_MAX.
REQ-024 Counter reaching WAIT_MAX while still waiting SHALL move to HANG and set err.
REQ-025 HANG: all four stalls asserted, flushes 0, mdu_go 0; exit only by reset.
REQ-026 err SHALL remain 1 until reset.

Reset
REQ-027 rstn low SHALL immediately force state=RUN, counter=0, err=0, including mid-wait; combinational outputs then follow RUN rules.
REQ-028 First edge after rstn release SHALL evaluate RUN normally; no pending mdu_go retained.

Structure
REQ-029 State encoding and WAIT_MAX default SHALL live in shared package pipe_ctrl_pkg.
REQ-030 Saturating counter SHALL be sub-module wait_timer (inputs clr, en; output expired).

Verification
REQ-031 Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> fstall=dstall=eflush=1 one cycle; ex_rd=0 case -> none.
REQ-032 Branch vs load-use same cycle: ex_br_taken=1 plus REQ-031 hazard -> dflush=eflush=1, fstall=0.
REQ-033 MDU: ex_mdu=1, mdu_done after 4 cycles -> mdu_go single pulse, stalls 5 cycles, state 0->1->0.
REQ-034 Mem wait plus ex_mdu: mem_ready low 3 cycles -> MEM_WAIT 3 cycles, then mdu_go on first RUN cycle.
REQ-035 Hang: WAIT_MAX=4, mem_ready held 0 -> state=3 and err=1 after 4 wait cycles; rstn pulse mid-HANG -> state=0, err=0.
